// File: rtl/wb_regfile_if.sv
// Bundle of the register-file signals shared by decode, writeback and the
// hazard logic.
//   slave  : the register file itself (takes writeback/read/issue, drives
//            read data, hazard and the writeback counter)
//   master : the pipeline side driving those requests
// Parameters XLEN (data width) and NREG (register count) must match the
// wb_regfile instance they are connected to.
interface wb_regfile_if #(
  parameter int XLEN = 64,
  parameter int NREG = 32
);
  localparam int AW = $clog2(NREG);

  // writeback port (MEM/WB stage register)
  logic [AW-1:0]   wb_wd;
  logic            wb_wreg;
  logic [XLEN-1:0] wb_wdata;

  // decode-stage read ports
  logic [AW-1:0]   rs1_addr;
  logic [AW-1:0]   rs2_addr;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  // issue / scoreboard control
  logic            iss_valid;
  logic            iss_wreg;
  logic [AW-1:0]   iss_rd;
  logic            flush;
  logic            hazard;

  // accepted-writeback counter
  logic [63:0]     wb_count;

  modport slave (
    input  wb_wd, wb_wreg, wb_wdata,
    input  rs1_addr, rs2_addr,
    input  iss_valid, iss_wreg, iss_rd, flush,
    output rs1_data, rs2_data, hazard, wb_count
  );

  modport master (
    output wb_wd, wb_wreg, wb_wdata,
    output rs1_addr, rs2_addr,
    output iss_valid, iss_wreg, iss_rd, flush,
    input  rs1_data, rs2_data, hazard, wb_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Integer register file with writeback bypass, a pending-write scoreboard
// for RAW hazard detection, and a 64-bit count of accepted writebacks.
// Ports:
//   clk    : single clock, all state updates on its rising edge
//   rst_n  : asynchronous reset, active-HIGH despite the name (1 = reset);
//            clears registers, pending bits and the counter immediately
//   bus    : wb_regfile_if.slave
//            wb_wd/wb_wreg/wb_wdata   writeback (x0 writes are dropped)
//            rs1/rs2_addr -> _data    combinational reads with same-cycle
//                                     bypass of the writeback data
//            iss_valid/iss_wreg/iss_rd mark a destination as pending
//            flush                    drops every pending mark
//            hazard                   a nonzero source is still pending and
//                                     not being written back this cycle
//            wb_count                 accepted writebacks since reset (wraps)
module wb_regfile #(
  parameter int XLEN = 64,
  parameter int NREG = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  wb_regfile_if.slave  bus
);

  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [63:0]     wb_count_q;

  logic            wr_en;
  logic            set_en;
  logic            hz_rs1;
  logic            hz_rs2;

  // A writeback to x0 is not a write at all: no storage update, no pending
  // clear, no count.
  assign wr_en  = bus.wb_wreg && (bus.wb_wd != '0);
  assign set_en = bus.iss_valid && bus.iss_wreg && (bus.iss_rd != '0);

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[bus.wb_wd] <= bus.wb_wdata;
    end
  end

  // x0 reads as zero; a matching writeback is forwarded in the same cycle so
  // decode never sees the stale value.  The bypass is purely combinational
  // and therefore also works while reset is held.
  function automatic logic [XLEN-1:0] read_src(input logic [AW-1:0] addr);
    logic [XLEN-1:0] val;
    if (addr == '0) begin
      val = '0;
    end else if (bus.wb_wreg && (bus.wb_wd == addr)) begin
      val = bus.wb_wdata;
    end else begin
      val = regs[addr];
    end
    return val;
  endfunction

  always_comb begin
    bus.rs1_data = read_src(bus.rs1_addr);
    bus.rs2_data = read_src(bus.rs2_addr);
  end

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  // The clear is applied before the set so that a same-register set/clear
  // pair leaves the bit at 1: the issuing instruction is a newer producer
  // than the one retiring.
  always_comb begin
    pending_d = pending_q;
    if (wr_en) begin
      pending_d[bus.wb_wd] = 1'b0;
    end
    if (set_en) begin
      pending_d[bus.iss_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Flush overrides any set in the same cycle; the storage write and the
  // counter are unaffected by flush.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pending_q <= '0;
    end else if (bus.flush) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // A source that is being written back this cycle is already satisfied by
  // the bypass, so it does not stall even though its pending bit is still 1.
  always_comb begin
    hz_rs1 = (bus.rs1_addr != '0) && pending_q[bus.rs1_addr] &&
             !(wr_en && (bus.wb_wd == bus.rs1_addr));
    hz_rs2 = (bus.rs2_addr != '0) && pending_q[bus.rs2_addr] &&
             !(wr_en && (bus.wb_wd == bus.rs2_addr));
  end

  assign bus.hazard = hz_rs1 || hz_rs2;

  // ---------------------------------------------------------------------
  // Writeback counter (natural 64-bit wrap)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wb_count_q <= '0;
    end else if (wr_en) begin
      wb_count_q <= wb_count_q + 64'd1;
    end
  end

  assign bus.wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
module tb_wb_regfile;

  localparam int XLEN = 64;
  localparam int NREG = 32;

  logic clk;
  logic rst_n;

  wb_regfile_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

  wb_regfile #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: architectural state as plain arrays.
  logic [63:0] m_regs [NREG];
  bit          m_pend [NREG];
  logic [63:0] m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0;
      m_pend[i] = 1'b0;
    end
    m_cnt = '0;
  endtask

  function automatic logic [63:0] m_read(input int a);
    if (a == 0) return 64'd0;
    if (bus.wb_wreg && int'(bus.wb_wd) == a) return bus.wb_wdata;
    return m_regs[a];
  endfunction

  function automatic bit m_src_hazard(input int a);
    bit clearing;
    clearing = bus.wb_wreg && int'(bus.wb_wd) == a;
    return (a != 0) && m_pend[a] && !clearing;
  endfunction

  // State update for one rising edge, from the rules of the block.
  task automatic m_edge();
    int wd;
    int rd;
    wd = int'(bus.wb_wd);
    rd = int'(bus.iss_rd);
    if (bus.wb_wreg && wd != 0) begin
      m_regs[wd] = bus.wb_wdata;
      m_cnt      = m_cnt + 64'd1;
      m_pend[wd] = 1'b0;
    end
    if (bus.flush) begin
      for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
    end else if (bus.iss_valid && bus.iss_wreg && rd != 0) begin
      m_pend[rd] = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rs1"}, bus.rs1_data, m_read(int'(bus.rs1_addr)));
    check({tag, ".rs2"}, bus.rs2_data, m_read(int'(bus.rs2_addr)));
    check({tag, ".haz"}, {63'd0, bus.hazard},
          {63'd0, m_src_hazard(int'(bus.rs1_addr)) || m_src_hazard(int'(bus.rs2_addr))});
    check({tag, ".cnt"}, bus.wb_count, m_cnt);
  endtask

  task automatic set_idle();
    bus.wb_wd     = '0;
    bus.wb_wreg   = 1'b0;
    bus.wb_wdata  = '0;
    bus.rs1_addr  = '0;
    bus.rs2_addr  = '0;
    bus.iss_valid = 1'b0;
    bus.iss_wreg  = 1'b0;
    bus.iss_rd    = '0;
    bus.flush     = 1'b0;
  endtask

  // Inputs are driven just after a falling edge; outputs are checked 1 time
  // unit later, then the rising edge is taken and the model follows it.
  task automatic step(input string tag);
    #1;
    check_outputs(tag);
    @(posedge clk);
    if (!rst_n) m_edge();
    @(negedge clk);
  endtask

  task automatic wb(input int wd, input logic [63:0] d);
    bus.wb_wreg  = 1'b1;
    bus.wb_wd    = 5'(wd);
    bus.wb_wdata = d;
  endtask

  task automatic issue(input int rd);
    bus.iss_valid = 1'b1;
    bus.iss_wreg  = 1'b1;
    bus.iss_rd    = 5'(rd);
  endtask

  initial begin
    rst_n = 1'b1;
    set_idle();
    m_reset();
    #2;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b0;

    // write then read
    set_idle(); wb(5, 64'h1234); step("w5");
    set_idle(); bus.rs1_addr = 5'd5; #1;
    check("wr_rd.data", bus.rs1_data, 64'h1234);
    check("wr_rd.cnt", bus.wb_count, 64'd1);
    step("r5");

    // bypass and x0
    set_idle(); wb(7, 64'hAA); bus.rs2_addr = 5'd7; #1;
    check("bypass", bus.rs2_data, 64'hAA);
    step("byp");
    set_idle(); wb(0, 64'hFF); bus.rs1_addr = 5'd0; step("w0");
    set_idle(); bus.rs1_addr = 5'd0; #1;
    check("x0.data", bus.rs1_data, 64'd0);
    check("x0.cnt", bus.wb_count, 64'd2);
    step("r0");

    // scoreboard set / clear
    set_idle(); issue(3); step("iss3");
    set_idle(); bus.rs1_addr = 5'd3; #1;
    check("sb.pend", {63'd0, bus.hazard}, 64'd1);
    step("pend3");
    set_idle(); bus.rs1_addr = 5'd3; wb(3, 64'h55AA); #1;
    check("sb.clr_haz", {63'd0, bus.hazard}, 64'd0);
    check("sb.clr_data", bus.rs1_data, 64'h55AA);
    step("clr3");
    set_idle(); bus.rs1_addr = 5'd3; #1;
    check("sb.after", {63'd0, bus.hazard}, 64'd0);
    step("after3");

    // same-register set and clear: set wins
    set_idle(); issue(4); step("iss4");
    set_idle(); issue(4); wb(4, 64'h44); step("setclr4");
    set_idle(); bus.rs1_addr = 5'd4; #1;
    check("sb.setwins", {63'd0, bus.hazard}, 64'd1);
    step("pend4");
    set_idle(); wb(4, 64'h45); issue(8); step("clr4set8");

    // flush beats a same-cycle issue, but the write still lands
    set_idle(); issue(2); step("iss2");
    set_idle(); issue(9); step("iss9");
    set_idle(); issue(10); bus.flush = 1'b1; wb(11, 64'hB0B); step("flush");
    set_idle(); bus.rs1_addr = 5'd2; bus.rs2_addr = 5'd9; #1;
    check("flush.x2x9", {63'd0, bus.hazard}, 64'd0);
    step("fl_a");
    set_idle(); bus.rs1_addr = 5'd10; bus.rs2_addr = 5'd11; #1;
    check("flush.x10", {63'd0, bus.hazard}, 64'd0);
    check("flush.wr", bus.rs2_data, 64'hB0B);
    step("fl_b");

    // mid-stream asynchronous reset
    set_idle(); issue(6); wb(12, 64'hC0FFEE); step("pre_rst");
    set_idle(); bus.rs1_addr = 5'd12; bus.rs2_addr = 5'd6;
    #2;
    rst_n = 1'b1;
    m_reset();
    #1;
    check("rst.rs1", bus.rs1_data, 64'd0);
    check("rst.haz", {63'd0, bus.hazard}, 64'd0);
    check("rst.cnt", bus.wb_count, 64'd0);
    wb(5, 64'hDEAD); bus.rs1_addr = 5'd5; issue(5); #1;
    check("rst.bypass", bus.rs1_data, 64'hDEAD);
    @(posedge clk);
    @(negedge clk);
    set_idle(); bus.rs1_addr = 5'd5; #1;
    check("rst.nowrite", bus.rs1_data, 64'd0);
    check("rst.nocnt", bus.wb_count, 64'd0);
    rst_n = 1'b0;
    step("post_rst");

    // randomized traffic, addresses often drawn from a small window so that
    // set/clear/read collisions are frequent
    for (int n = 0; n < 400; n++) begin
      bit narrow;
      narrow        = ($urandom_range(0, 1) == 1);
      bus.wb_wreg   = ($urandom_range(0, 2) != 0);
      bus.wb_wd     = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      bus.wb_wdata  = {$urandom, $urandom};
      bus.rs1_addr  = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      bus.rs2_addr  = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      bus.iss_valid = ($urandom_range(0, 3) != 0);
      bus.iss_wreg  = ($urandom_range(0, 3) != 0);
      bus.iss_rd    = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom_range(0, 31));
      bus.flush     = ($urandom_range(0, 31) == 0);
      step("rand");
    end

    // counter wrap
    set_idle();
    force dut.wb_count_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.wb_count_q;
    m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    step("wrap_pre");
    set_idle(); wb(1, 64'h1); step("wrap_wb");
    set_idle(); #1;
    check("wrap.cnt", bus.wb_count, 64'd0);
    step("wrap_post");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter XLEN, default 64, data width of every register and of the write/read data ports.
REQ-002 Parameter NREG, default 32, number of architectural registers; the address width is log2(NREG), 5 by default.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-high (asserted = 1).
REQ-005 wb_wd  input  5  writeback destination register address, from the MEM/WB stage register.
REQ-006 wb_wreg  input  1  writeback enable.
REQ-007 wb_wdata  input  XLEN  writeback data.
REQ-008 rs1_addr, rs2_addr  input  5 each  decode-stage read addresses.
REQ-009 rs1_data, rs2_data  output  XLEN each  combinational read data.
REQ-010 iss_valid  input  1  decode issues an instruction this cycle.
REQ-011 iss_wreg  input  1  the issued instruction writes a register.
REQ-012 iss_rd  input  5  destination register of the issued instruction.
REQ-013 flush  input  1  pipeline flush; discards all pending-write marks.
REQ-014 hazard  output  1  combinational; a requested source has an outstanding producer.
REQ-015 wb_count  output  64  number of accepted register writebacks since reset.

Function
REQ-016 Storage: NREG x XLEN registers; register 0 reads as 0 always and is never written.
REQ-017 Write: at posedge, if wb_wreg=1 and wb_wd!=0, reg[wb_wd] <= wb_wdata; wb_wreg=0 leaves all registers unchanged.
REQ-018 Read: rsN_data = 0 if rsN_addr=0; else wb_wdata if wb_wreg=1 and wb_wd=rsN_addr (same-cycle bypass); else reg[rsN_addr].
REQ-019 Scoreboard: one pending bit per register; bit 0 is constant 0.
REQ-020 Set: at posedge, iss_valid=1, iss_wreg=1 and iss_rd!=0 set pending[iss_rd].
REQ-021 Clear: at posedge, wb_wreg=1 and wb_wd!=0 clear pending[wb_wd].
REQ-022 When set and clear hit the same register in the same cycle, set wins and the bit stays 1 (newer producer).
REQ-023 When set and clear hit different registers in the same cycle, both take effect.
REQ-024 flush=1 at posedge clears all pending bits; a set in the same cycle is ignored (flush wins); the register write in that cycle still happens.
REQ-025 hazard = 1 if, for rs1_addr or rs2_addr (nonzero), pending[addr]=1 and that register is not being cleared this cycle (wb_wreg=1, wb_wd=addr); otherwise 0.
REQ-026 hazard depends only on current state and inputs; iss_valid does not gate it.
REQ-027 wb_count increments by 1 at each posedge with wb_wreg=1 and wb_wd!=0; it wraps from 2^64-1 to 0; flush has no effect on it.
REQ-028 Latency: a write becomes visible through storage one cycle after wb_wreg, and through the bypass in the same cycle.

Reset
REQ-029 When rst_n=1, asynchronously and without waiting for clk: all registers = 0, all pending bits = 0, wb_count = 0; hence hazard = 0 and rsN_data = 0 for any address with no writeback active.
REQ-030 While rst_n=1, the write, scoreboard and counter updates are suppressed; the combinational bypass of REQ-018 still applies.
REQ-031 Reset asserted mid-operation (pending bits set, count nonzero) clears all state immediately; the first edge after deassertion behaves as after power-up.

Verification
REQ-032 Write then read: wb_wd=5, wb_wreg=1, wb_wdata=0x1234 for one cycle, then rs1_addr=5 -> rs1_data=0x1234; wb_count=1.
REQ-033 Bypass and x0: same-cycle wb_wd=7, wdata=0xAA, rs2_addr=7 -> rs2_data=0xAA; write wb_wd=0, wdata=0xFF -> rs1_addr=0 reads 0 and wb_count is unchanged.
REQ-034 Scoreboard: issue rd=3, then rs1_addr=3 -> hazard=1; the cycle with wb_wd=3, wb_wreg=1 -> hazard=0 and rs1_data=wb_wdata; the next cycle -> hazard=0.
REQ-035 Simultaneous set and clear: pending[4]=1, issue rd=4 and writeback wd=4 in the same cycle -> next cycle hazard=1 for rs1_addr=4.
REQ-036 Flush and reset: pending on x2 and x9, flush=1 together with issue rd=10 -> next cycle no hazard on x2, x9 or x10; then assert rst_n mid-stream -> all reads return 0, hazard=0 and wb_count=0 before the next clk edge.
REQ-037 Counter wrap: force wb_count to 2^64-1, then one valid writeback -> wb_count=0.
